// File: rtl/divider8_seq.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake. The per-iteration compare uses Comparator8Bit.

module Comparator8Bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       lt
);
    assign lt = (a < b);
endmodule

module divider8_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     r_state;
    logic [7:0] r_q;
    logic [7:0] r_d;
    logic [7:0] r_r;
    logic [2:0] r_cnt;

    logic       w_c;
    logic [7:0] w_s;
    logic       w_lt;
    logic       w_sub;
    logic [7:0] w_r_next;
    logic [7:0] w_q_next;

    // {c,S} is the 9-bit shifted partial remainder; c=1 means it already exceeds D.
    assign w_c      = r_r[7];
    assign w_s      = {r_r[6:0], r_q[7]};
    assign w_sub    = w_c | ~w_lt;
    assign w_r_next = w_sub ? (w_s - r_d) : w_s;
    assign w_q_next = {r_q[6:0], w_sub};

    Comparator8Bit u_cmp (
        .a  (w_s),
        .b  (r_d),
        .lt (w_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == 8'd0) begin
                            quotient    <= 8'hFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_q         <= dividend;
                            r_d         <= divisor;
                            r_r         <= '0;
                            r_cnt       <= '0;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            r_state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        quotient  <= w_q_next;
                        remainder <= w_r_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider8_seq.sv
// Directed and random checks of divider8_seq against plain-arithmetic division.

module tb_divider8_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int errs   = 0;
    int checks = 0;

    divider8_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full divide: issue, watch handshake timing, compare against a/b and a%b.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] eq, er, oq;
        logic       ez;
        int         lat, nbusy, chg;
        bit         seen;
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; ez = 1'b1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0;
        end
        @(negedge clk);
        oq = quotient;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        lat = 0; nbusy = 0; chg = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end else if (quotient !== oq) chg++;
        end
        chk({tag, " latency"}, lat, (b == 8'd0) ? 1 : 9);
        chk({tag, " busy_cycles"}, nbusy, (b == 8'd0) ? 0 : 8);
        chk({tag, " early_change"}, chg, 0);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, div_by_zero, ez);
        @(negedge clk);
        chk({tag, " done_width"}, done, 0);
    endtask

    initial begin
        int ndone;
        logic [7:0] rq, rr, ra, rb;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #3;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_div(8'd200, 8'd7,   "200/7");
        run_div(8'd255, 8'd200, "255/200");
        run_div(8'd250, 8'd129, "250/129");
        run_div(8'd255, 8'd1,   "255/1");
        run_div(8'd5,   8'd9,   "5/9");
        run_div(8'd0,   8'd3,   "0/3");
        run_div(8'd128, 8'd128, "128/128");
        run_div(8'd77,  8'd0,   "77/0");
        run_div(8'd10,  8'd2,   "10/2");

        // Second start during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd10;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; rq = '0; rr = '0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                rq = quotient; rr = remainder;
            end
        end
        chk("ignored_start done_count", ndone, 1);
        chk("ignored_start quotient", rq, 10);
        chk("ignored_start remainder", rr, 0);
        chk("ignored_start hold_q", quotient, 10);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset quotient", quotient, 0);
        chk("midreset remainder", remainder, 0);
        chk("midreset dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("midreset no_activity", ndone, 0);
        run_div(8'd50, 8'd5, "50/5");

        for (int k = 0; k < 30; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_div(ra, rb, "random");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
